// File: rtl/partial_product_sequencer.sv
// partial_product_sequencer
//
// Sequences an unsigned HBits x HBits shift-and-add multiplication for an
// external accumulator. For each accepted start it issues a one-cycle clear
// pulse and then one partial product per multiplier bit, LSB first. The
// partial products sum to multiplicand * multiplier.
//
// Ports
//   clk          : single clock, all state updates on its rising edge
//   reset        : synchronous active-low reset
//   start        : request a new multiplication (accepted in IDLE or DONE)
//   multiplicand : operand A, captured on an accepted start
//   multiplier   : operand B, captured on an accepted start
//   pp           : registered partial product for the accumulator data input
//   sys_reset    : registered one-cycle accumulator clear pulse
//   ready        : registered, low only while partial products are issued
//   busy         : registered, high from accepted start until DONE
//   done         : registered one-cycle pulse on entry to DONE

module partial_product_sequencer #(
    parameter int NBits = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NBits/2-1:0]   multiplicand,
    input  logic [NBits/2-1:0]   multiplier,
    output logic [NBits-1:0]     pp,
    output logic                 sys_reset,
    output logic                 ready,
    output logic                 busy,
    output logic                 done
);

    localparam int HBits = NBits / 2;
    localparam int IdxW  = (HBits > 1) ? $clog2(HBits) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(HBits - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [HBits-1:0]  a_reg, a_next;
    logic [HBits-1:0]  b_reg, b_next;
    logic [IdxW-1:0]   idx, idx_next;

    logic [NBits-1:0]  pp_next;
    logic              sys_reset_next;
    logic              ready_next;
    logic              busy_next;
    logic              done_next;

    // Next-state and next-output logic. The outputs are registered, so they
    // are derived from the state being entered rather than the current one;
    // this keeps each output aligned with the state it describes.
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = multiplicand;
                    b_next     = multiplier;
                    idx_next   = '0;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                idx_next   = '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (idx == LastIdx) begin
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Zero-extend A to the full product width before shifting so the
        // top bits survive the largest shift.
        pp_next = '0;
        if (state_next == SHIFT && b_next[idx_next]) begin
            pp_next = {{HBits{1'b0}}, a_next} << idx_next;
        end

        sys_reset_next = (state_next == CLEAR);
        ready_next     = (state_next != SHIFT);
        busy_next      = (state_next == CLEAR) || (state_next == SHIFT);
        // Pulse only on the transition into DONE, not while parked there.
        done_next      = (state_next == DONE) && (state != DONE);
    end

    // State, operand and output registers with synchronous active-low reset
    // taking priority over everything, including a simultaneous start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            pp        <= '0;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx       <= idx_next;
            pp        <= pp_next;
            sys_reset <= sys_reset_next;
            ready     <= ready_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_partial_product_sequencer.sv
// tb_partial_product_sequencer
//
// Directed bench for partial_product_sequencer with NBits = 16. Inputs are
// driven and outputs sampled on the falling clock edge.

module tb_partial_product_sequencer;

    localparam int NBits = 16;
    localparam int HBits = NBits / 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic [HBits-1:0]  multiplicand;
    logic [HBits-1:0]  multiplier;
    logic [NBits-1:0]  pp;
    logic              sys_reset;
    logic              ready;
    logic              busy;
    logic              done;

    int passCount;
    int checkCount;

    partial_product_sequencer #(.NBits(NBits)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .pp           (pp),
        .sys_reset    (sys_reset),
        .ready        (ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic [HBits-1:0] a,
                                 input logic [HBits-1:0] b);
        start        = s;
        multiplicand = a;
        multiplier   = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkIdleLike(input string tag, input logic expDone);
        checkOutput({tag, ".pp"},        32'(pp), 32'd0);
        checkOutput({tag, ".sys_reset"}, 32'(sys_reset), 32'd0);
        checkOutput({tag, ".ready"},     32'(ready), 32'd1);
        checkOutput({tag, ".busy"},      32'(busy), 32'd0);
        checkOutput({tag, ".done"},      32'(done), 32'(expDone));
    endtask

    // One full operation started from IDLE or DONE. Operands are scrambled
    // after the accepting edge; optionally a second start is raised during
    // SHIFT i=3, which must be ignored.
    task automatic runOp(input string tag, input logic [HBits-1:0] a,
                         input logic [HBits-1:0] b, input int expSum,
                         input bit midStart);
        int sum;
        logic [NBits-1:0] expPp;
        sum = 0;
        applyStimulus(1'b1, a, b);
        @(negedge clk);
        applyStimulus(1'b0, ~a, ~b);
        checkOutput({tag, ".clr.sys_reset"}, 32'(sys_reset), 32'd1);
        checkOutput({tag, ".clr.ready"},     32'(ready), 32'd1);
        checkOutput({tag, ".clr.busy"},      32'(busy), 32'd1);
        checkOutput({tag, ".clr.pp"},        32'(pp), 32'd0);
        for (int i = 0; i < HBits; i++) begin
            @(negedge clk);
            if (midStart && i == 3) applyStimulus(1'b1, 8'd1, 8'd1);
            else                    applyStimulus(1'b0, 8'd1, 8'd1);
            expPp = b[i] ? (NBits'(a) << i) : '0;
            checkOutput($sformatf("%s.shift%0d.pp", tag, i), 32'(pp), 32'(expPp));
            checkOutput($sformatf("%s.shift%0d.ready", tag, i), 32'(ready), 32'd0);
            checkOutput($sformatf("%s.shift%0d.busy", tag, i), 32'(busy), 32'd1);
            sum += int'(pp);
        end
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 8'd0);
        checkIdleLike({tag, ".done1"}, 1'b1);
        checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
        @(negedge clk);
        checkIdleLike({tag, ".done2"}, 1'b0);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b0;
        applyStimulus(1'b1, 8'd5, 8'd3);

        // Reset overrides a simultaneous start.
        repeat (2) @(negedge clk);
        checkIdleLike("reset", 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 8'd0, 8'd0);
        @(negedge clk);
        checkIdleLike("idle", 1'b0);

        // 5*3: pp = 5, 10, then zeros.
        runOp("op5x3", 8'd5, 8'd3, 15, 1'b0);
        // 255*255: largest product, no overflow.
        runOp("op255x255", 8'd255, 8'd255, 65025, 1'b0);
        // B = 0: eight zero partial products, ready still low for eight cycles.
        runOp("opABx0", 8'hAB, 8'd0, 0, 1'b0);
        // A = 0 also runs the full sequence.
        runOp("op0x5A", 8'd0, 8'h5A, 0, 1'b0);
        // 7*9 with a start raised mid-operation.
        runOp("op7x9", 8'd7, 8'd9, 63, 1'b1);

        // Reset during SHIFT i=4 aborts the operation.
        applyStimulus(1'b1, 8'h55, 8'hFF);
        @(negedge clk);
        applyStimulus(1'b0, 8'h55, 8'hFF);
        repeat (5) @(negedge clk);
        checkOutput("abort.pre.pp", 32'(pp), 32'(16'h55 << 4));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkIdleLike("abort", 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abort.quiet%0d.pp", c), 32'(pp), 32'd0);
        end
        runOp("op2x2", 8'd2, 8'd2, 4, 1'b0);

        // start held high: back-to-back operations every HBits+2 cycles.
        applyStimulus(1'b1, 8'd3, 8'd5);
        for (int c = 1; c <= 2 * (HBits + 2); c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b.c%0d.sys_reset", c), 32'(sys_reset),
                        32'(c == 1 || c == HBits + 3));
            checkOutput($sformatf("b2b.c%0d.done", c), 32'(done),
                        32'(c == HBits + 2 || c == 2 * (HBits + 2)));
        end
        applyStimulus(1'b0, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        checkIdleLike("b2b.end", 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/partial_product_sequencer.md
PARTIAL_PRODUCT_SEQUENCER -- requirements
Module: partial_product_sequencer

Interface
REQ-001 Parameter: NBits, default 16, product / partial-product width; SHALL be even and >= 4.
REQ-002 Derived: HBits = NBits/2, operand width; not overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 start  input  1  request a new multiplication; sampled each cycle.
REQ-006 multiplicand  input  HBits  unsigned operand A; captured on accepted start.
REQ-007 multiplier  input  HBits  unsigned operand B; captured on accepted start.
REQ-008 pp  output  NBits  partial product fed to the accumulator's data input; registered.
REQ-009 sys_reset  output  1  one-cycle accumulator clear pulse; registered.
REQ-010 ready  output  1  high when no partial products are being issued; accumulator adds only while low; registered.
REQ-011 busy  output  1  high from accepted start until the DONE state is entered; registered.
REQ-012 done  output  1  one-cycle pulse on entry to DONE; registered.

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE; encoding is free.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in CLEAR or SHIFT SHALL be ignored, with no effect on operands or sequence.
REQ-015 Accepted start: latch A = multiplicand, B = multiplier, bit index i = 0; go to CLEAR.
REQ-016 CLEAR (exactly 1 cycle): sys_reset=1, ready=1, pp=0, busy=1; then go to SHIFT.
REQ-017 SHIFT (exactly HBits cycles, i = 0..HBits-1): ready=0, sys_reset=0, busy=1.
REQ-018 SHIFT output: pp = ({HBits zeros, A} << i) when B[i]=1, else pp = 0.
REQ-019 Shift arithmetic SHALL be zero-extended NBits unsigned; no bit is lost for any i <= HBits-1.
REQ-020 After the SHIFT cycle with i = HBits-1, the FSM SHALL go to DONE.
REQ-021 DONE: ready=1, pp=0, sys_reset=0, busy=0; done=1 on the first DONE cycle only. The FSM SHALL remain in DONE until an accepted start.
REQ-022 IDLE: ready=1, pp=0, sys_reset=0, busy=0, done=0.
REQ-023 Latency: start sampled at edge k -> sys_reset=1 during cycle k+1; pp for bit i during cycle k+2+i; ready=1 and done=1 during cycle k+2+HBits. Total = HBits+2 cycles.
REQ-024 Sum of pp over all SHIFT cycles SHALL equal A*B exactly; the maximum is (2^HBits-1)^2 < 2^NBits.
REQ-025 Operand inputs SHALL be ignored outside the accepting cycle; changing them mid-operation SHALL NOT alter pp.
REQ-026 Start accepted in DONE (back-to-back) SHALL behave identically to start from IDLE; done SHALL NOT re-pulse.
REQ-027 Zero operand (A=0 or B=0): full HBits SHIFT cycles with pp=0; latency unchanged.

Reset
REQ-028 reset=0 at an edge SHALL force IDLE with pp=0, sys_reset=0, ready=1, busy=0, done=0, i=0, and A=B=0, overriding start.
REQ-029 Reset during CLEAR or SHIFT SHALL abort the operation; no further nonzero pp SHALL be issued until a new accepted start.
REQ-030 Reset SHALL have priority over every other condition in the same cycle.

Verification
REQ-031 NBits=16; A=5, B=3, start 1 cycle -> sys_reset pulse; pp = 5, 10, then 0 x6; ready high at k+10; pp sum 15.
REQ-032 A=255, B=255 -> pp = 255<<i for i=0..7; sum 65025; no overflow; done pulses exactly once.
REQ-033 A=0xAB, B=0 -> 8 SHIFT cycles with pp=0, ready low for exactly 8 cycles, sum 0.
REQ-034 A=7, B=9 started; start with A=1, B=1 asserted during SHIFT i=3 -> ignored; sum 63; operand change mid-op has no effect.
REQ-035 Reset asserted during SHIFT i=4 -> next cycle IDLE, ready=1, pp=0, busy=0; a new start (A=2, B=2) then yields sum 4.
REQ-036 start held high continuously -> back-to-back operations every HBits+2 cycles, each beginning with a sys_reset pulse.
